// File: rtl/record_serializer.sv
// Record-wide FIFO that buffers up to SLOTS whole records and serializes each
// one as RECORD_SIZE words, word 0 first, with first-word fall-through reads.
module record_serializer #(
    parameter int INPUT_SIZE_BYTES = 1,
    parameter int RECORD_SIZE      = 4,
    parameter int SLOTS            = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      write_en,
    input  logic [RECORD_SIZE*INPUT_SIZE_BYTES*8-1:0] data_in,
    output logic                                      full,
    input  logic                                      read_en,
    output logic                                      empty,
    output logic [INPUT_SIZE_BYTES*8-1:0]             data_out,
    output logic                                      last_word,
    output logic [$clog2(SLOTS):0]                    level
);

    localparam int W     = INPUT_SIZE_BYTES * 8;
    localparam int REC_W = RECORD_SIZE * W;
    localparam int AW    = $clog2(SLOTS);
    localparam int PW    = AW + 1;
    localparam int IW    = (RECORD_SIZE > 1) ? $clog2(RECORD_SIZE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RECORD_SIZE - 1);

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [IW-1:0]    word_idx_r;
    logic [REC_W-1:0] mem_r [SLOTS];

    logic [PW-1:0]    level_s;
    logic             empty_s;
    logic             full_s;
    logic             wr_accept_s;
    logic             pop_s;
    logic             final_pop_s;
    logic [REC_W-1:0] cur_rec_s;

    // Status decode from registered pointers only; the wrap bit separates full from empty.
    always_comb begin
        level_s     = wr_ptr_r - rd_ptr_r;
        empty_s     = (level_s == {PW{1'b0}});
        full_s      = (level_s == PW'(SLOTS));
        wr_accept_s = write_en & ~full_s;
        pop_s       = read_en & ~empty_s;
        final_pop_s = pop_s & (word_idx_r == LAST_IDX);
    end

    assign level     = level_s;
    assign empty     = empty_s;
    assign full      = full_s;
    assign last_word = ~empty_s & (word_idx_r == LAST_IDX);

    // Pointer and word-index state; reset discards everything, partial record included.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            word_idx_r <= {IW{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (final_pop_s) begin
                word_idx_r <= {IW{1'b0}};
                rd_ptr_r   <= rd_ptr_r + PW'(1);
            end else if (pop_s) begin
                word_idx_r <= word_idx_r + IW'(1);
            end
        end
    end

    // Record storage; an accepted write always targets a slot other than the one being read.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_in;
        end
    end

    // Fall-through word select, forced to zero while nothing is stored.
    always_comb begin
        cur_rec_s = mem_r[rd_ptr_r[AW-1:0]];
        if (empty_s) begin
            data_out = {W{1'b0}};
        end else begin
            data_out = cur_rec_s[int'(word_idx_r) * W +: W];
        end
    end

endmodule
